// File: rtl/logic_sweep_unit.sv
// Clocked bitwise two-input function unit: evaluates one registered (x, y) row,
// or sweeps every operand pair like a truth-table generator, over valid/ready.
module logic_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [WIDTH-1:0]   s_out,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   nz_count
);

    // Handshake: a row transfers on every rising edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the row holds.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         op_q, op_nxt;
    logic               mode_q, mode_nxt;
    logic [WIDTH-1:0]   x_q, x_nxt;
    logic [WIDTH-1:0]   y_q, y_nxt;
    logic [WIDTH-1:0]   s_q, s_nxt;
    logic [2*WIDTH:0]   nz_q, nz_nxt;
    logic [2*WIDTH-1:0] xy_inc;
    logic               accept;
    logic               last_row;

    function automatic logic [WIDTH-1:0] eval_fn(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (f)
            3'd0:    r = x & ~y;
            3'd1:    r = ~(x | y);
            3'd2:    r = ~(x & y);
            3'd3:    r = x | y;
            3'd4:    r = x & y;
            3'd5:    r = x ^ y;
            3'd6:    r = ~(x ^ y);
            default: r = ~x;
        endcase
        return r;
    endfunction

    assign accept   = (state == S_RUN) && out_ready;
    assign last_row = &{x_q, y_q};
    // y is the low half, so the sweep walks y fastest.
    assign xy_inc   = {x_q, y_q} + (2*WIDTH)'(1);

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        mode_nxt  = mode_q;
        x_nxt     = x_q;
        y_nxt     = y_q;
        nz_nxt    = nz_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    op_nxt    = op;
                    mode_nxt  = mode;
                    nz_nxt    = '0;
                    x_nxt     = mode ? '0 : a;
                    y_nxt     = mode ? '0 : b;
                end
            end
            S_RUN: begin
                // A row accepted on the abort edge still counts.
                if (accept && (s_q != '0))
                    nz_nxt = nz_q + (2*WIDTH+1)'(1);
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept) begin
                    if (!mode_q || last_row)
                        state_nxt = S_DONE;
                    else
                        {x_nxt, y_nxt} = xy_inc;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        s_nxt = eval_fn(op_nxt, x_nxt, y_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            mode_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            s_q    <= '0;
            nz_q   <= '0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            mode_q <= mode_nxt;
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            s_q    <= s_nxt;
            nz_q   <= nz_nxt;
        end
    end

    assign out_valid = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign s_out     = s_q;
    assign nz_count  = nz_q;

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Bench for logic_sweep_unit: truth-table row model with an expected-row queue,
// per-cycle compare on the falling edge, plus hand-computed literal checks.
module tb_logic_sweep_unit;

    localparam int W  = 4;
    localparam int W1 = 1;

    logic           clk;
    logic           rst_n;
    logic           start, mode, abort, out_ready;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           out_valid, busy, done;
    logic [W-1:0]   x_out, y_out, s_out;
    logic [2*W:0]   nz_count;

    logic           start1;
    logic           out_valid1, busy1, done1;
    logic [W1-1:0]  x_out1, y_out1, s_out1;
    logic [2*W1:0]  nz_count1;

    int vec_count = 0;
    int err_count = 0;
    int done_seen = 0;

    // Model state: rows still owed by the DUT, a pending done pulse, nz tally.
    logic [3*W-1:0] exp_q[$];
    logic           done_m  = 1'b0;
    int             m_nz    = 0;
    logic           rowzero = 1'b1;

    // Truth tables indexed by {x_bit, y_bit}, one per op code.
    logic [3:0] tt [8] = '{4'b0100, 4'b0001, 4'b0111, 4'b1110,
                           4'b1000, 4'b0110, 4'b1001, 4'b0011};

    logic_sweep_unit #(.WIDTH(W)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .op(op),
        .a(a), .b(b), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .s_out(s_out),
        .busy(busy), .done(done), .nz_count(nz_count)
    );

    logic_sweep_unit #(.WIDTH(W1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(1'b1), .op(3'd0),
        .a(1'b0), .b(1'b0), .abort(1'b0), .out_ready(1'b1),
        .out_valid(out_valid1), .x_out(x_out1), .y_out(y_out1), .s_out(s_out1),
        .busy(busy1), .done(done1), .nz_count(nz_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_fn(input logic [2:0] f, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[f];
        for (int j = 0; j < W; j++) r[j] = t[{x[j], y[j]}];
        return r;
    endfunction

    function automatic void push_rows(input logic m, input logic [2:0] f,
                                      input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] xv, yv;
        if (!m) begin
            exp_q.push_back({av, bv, model_fn(f, av, bv)});
        end else begin
            for (int i = 0; i < (1 << (2*W)); i++) begin
                xv = W'(i >> W);
                yv = W'(i % (1 << W));
                exp_q.push_back({xv, yv, model_fn(f, xv, yv)});
            end
        end
    endfunction

    // Compare, then advance the model using the inputs the next edge will sample.
    initial begin
        logic [3*W-1:0] head;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                done_m  = 1'b0;
                m_nz    = 0;
                rowzero = 1'b1;
                check("rst_valid", 32'(out_valid), 0);
                check("rst_xys", 32'({x_out, y_out, s_out}), 0);
                check("rst_nz", 32'(nz_count), 0);
                check("rst_busy_done", 32'({busy, done}), 0);
            end else begin
                if (done) done_seen++;
                check("nz_count", 32'(nz_count), 32'(m_nz));
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    check("out_valid", 32'(out_valid), 1);
                    check("busy", 32'(busy), 1);
                    check("done_in_run", 32'(done), 0);
                    check("row_x", 32'(x_out), 32'(head[3*W-1 -: W]));
                    check("row_y", 32'(y_out), 32'(head[2*W-1 -: W]));
                    check("row_s", 32'(s_out), 32'(head[W-1:0]));
                end else begin
                    check("out_valid_idle", 32'(out_valid), 0);
                    check("busy_idle", 32'(busy), 0);
                    check("done", 32'(done), 32'(done_m));
                    if (rowzero) check("idle_xys", 32'({x_out, y_out, s_out}), 0);
                end
                if (done_m) begin
                    done_m = 1'b0;
                end else if (exp_q.size() == 0) begin
                    if (start) begin
                        m_nz    = 0;
                        rowzero = 1'b0;
                        push_rows(mode, op, a, b);
                    end
                end else begin
                    head = exp_q[0];
                    if (out_ready && head[W-1:0] != '0) m_nz++;
                    if (abort) begin
                        exp_q.delete();
                    end else if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_m = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic m, input logic [2:0] f,
                            input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1; mode = m; op = f; a = av; b = bv;
        tick();
        start = 1'b0; mode = ~m; op = ~f; a = ~av; b = ~bv;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_m) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; op = '0; a = '0; b = '0;
        abort = 1'b0; out_ready = 1'b0; start1 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single: ~(0101 | 0011) = 1000.
        start_op(1'b0, 3'd1, 4'b0101, 4'b0011);
        check("single_valid", 32'(out_valid), 1);
        check("single_s_lit", 32'(s_out), 32'h8);
        tick();
        out_ready = 1'b1;
        tick();
        check("single_done_lit", 32'(done), 1);
        out_ready = 1'b0;
        wait_idle("single", 10);
        check("single_nz_lit", 32'(nz_count), 1);

        // Full xor sweep: 16 rows with x==y give 0, so 240 non-zero.
        done_seen = 0;
        out_ready = 1'b1;
        start_op(1'b1, 3'd5, 4'h3, 4'h9);
        wait_idle("xor_sweep", 300);
        check("xor_nz_lit", 32'(nz_count), 240);
        check("xor_done_pulses", 32'(done_seen), 1);

        // Backpressure on row (0,2) of an or sweep, with a stray start mid-run.
        start_op(1'b1, 3'd3, 4'h0, 4'h0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_row_lit", 32'({x_out, y_out, s_out}), 32'h022);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_y_lit", 32'(y_out), 3);
        start_op(1'b0, 3'd7, 4'h5, 4'h5);
        wait_idle("or_sweep", 300);
        check("or_nz_lit", 32'(nz_count), 255);

        // Abort on the same edge as the accept of row 5 (s=5): 5 rows count.
        start_op(1'b1, 3'd3, 4'h0, 4'h0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid_lit", 32'(out_valid), 0);
        check("abort_done_lit", 32'(done), 0);
        check("abort_nz_lit", 32'(nz_count), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_idle_nz_lit", 32'(nz_count), 5);

        // Start held across several single operations.
        start = 1'b1; mode = 1'b0; op = 3'd0; a = 4'hC; b = 4'h5;
        repeat (8) tick();
        start = 1'b0;
        wait_idle("held_start", 10);
        check("held_nz_lit", 32'(nz_count), 1);

        // Asynchronous reset mid-sweep, then a fresh sweep from (0,0).
        start_op(1'b1, 3'd4, 4'h0, 4'h0);
        repeat (10) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_lit", 32'(out_valid), 0);
        check("async_rst_xys_lit", 32'({x_out, y_out, s_out}), 0);
        check("async_rst_nz_lit", 32'(nz_count), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_op(1'b1, 3'd4, 4'h0, 4'h0);
        check("restart_row_lit", 32'({x_out, y_out}), 0);
        wait_idle("and_sweep", 300);
        check("and_nz_lit", 32'(nz_count), 175);
        out_ready = 1'b0;

        // WIDTH=1 sweep of x & ~y.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w1_valid", 32'(out_valid1), 1);
            check("w1_row_lit", 32'({x_out1, y_out1, s_out1}),
                  (i == 0) ? 32'b000 : (i == 1) ? 32'b010 : (i == 2) ? 32'b101 : 32'b110);
            tick();
        end
        check("w1_done_lit", 32'({out_valid1, busy1, done1}), 32'b001);
        check("w1_nz_lit", 32'(nz_count1), 1);
        tick();
        check("w1_done_once", 32'(done1), 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
